// File: rtl/game_fsm.sv
`default_nettype none
// ============================================================================
// Module      : game_fsm
// Description : Game controller upstream of the LCD data wrapper.
//               - 2-flop synchronises the five raw buttons, then debounces
//                 each bit with its own stable-cycle counter.
//               - Generates a single-cycle start/pause press pulse.
//               - Runs the START / PLAYING / PAUSED / GAME_OVER machine that
//                 drives the wrapper's game_state input.
//               - Counts cleared waves (saturating at 15).
// Ports       : clk          in   pixel clock, single clock domain
//               rst_n        in   asynchronous active-low reset
//               buttons_raw  in   [4:0] raw buttons (0 shoot, 1 start/pause,
//                                 2 left, 3 spare, 4 right)
//               game_status  in   [2:0] wrapper feedback (0 player destroyed,
//                                 1 wave cleared, 2 invaders at ground)
//               buttons_db   out  [4:0] debounced button levels
//               game_state   out  [2:0] 000 START, 001 PLAYING, 010 PAUSED,
//                                 011 GAME_OVER
//               wave_count   out  [3:0] waves cleared in the current game
// Revision    : 1.0 - initial release
// ============================================================================
module game_fsm #(
    parameter int DEBOUNCE_CYCLES  = 330000,
    parameter int GAME_OVER_CYCLES = 99000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] buttons_raw,
    input  logic [2:0] game_status,
    output logic [4:0] buttons_db,
    output logic [2:0] game_state,
    output logic [3:0] wave_count
);

    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int c_GO_W = $clog2(GAME_OVER_CYCLES) + 1;

    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_GO_W-1:0] c_GO_LAST = c_GO_W'(GAME_OVER_CYCLES - 1);

    localparam logic [2:0] c_ST_START     = 3'b000;
    localparam logic [2:0] c_ST_PLAYING   = 3'b001;
    localparam logic [2:0] c_ST_PAUSED    = 3'b010;
    localparam logic [2:0] c_ST_GAME_OVER = 3'b011;

    localparam logic [3:0] c_WAVE_MAX = 4'd15;

    // ------------------------------------------------------------------
    // Button synchroniser
    // ------------------------------------------------------------------
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= buttons_raw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debounce: the counter measures how long the synchronised
    // level has disagreed with the accepted level; any agreement restarts it.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 5; gi++) begin : g_debounce
        logic [c_DB_W-1:0] r_cnt;
        logic              r_db_bit;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt    <= '0;
                r_db_bit <= 1'b0;
            end else if (r_sync2[gi] != r_db_bit) begin
                if (r_cnt == c_DB_LAST) begin
                    r_db_bit <= r_sync2[gi];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end

        assign buttons_db[gi] = r_db_bit;
    end

    // ------------------------------------------------------------------
    // Start/pause press pulse: one cycle per debounced rising edge, so a
    // held button yields exactly one press.
    // ------------------------------------------------------------------
    logic r_start_db_d;
    logic r_start_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_db_d  <= 1'b0;
            r_start_press <= 1'b0;
        end else begin
            r_start_db_d  <= buttons_db[1];
            r_start_press <= buttons_db[1] & ~r_start_db_d;
        end
    end

    // ------------------------------------------------------------------
    // Game state machine
    // ------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              w_clear_waves;
    logic [c_GO_W-1:0] r_go_timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clear_waves = 1'b0;
        case (r_state)
            c_ST_START: begin
                if (r_start_press) begin
                    w_state_nxt   = c_ST_PLAYING;
                    w_clear_waves = 1'b1;
                end
            end
            c_ST_PLAYING: begin
                // A fatal status wins over a simultaneous pause press.
                if (game_status[0] || game_status[2]) begin
                    w_state_nxt = c_ST_GAME_OVER;
                end else if (r_start_press) begin
                    w_state_nxt = c_ST_PAUSED;
                end
            end
            c_ST_PAUSED: begin
                if (r_start_press) begin
                    w_state_nxt = c_ST_PLAYING;
                end
            end
            c_ST_GAME_OVER: begin
                // A press in the first GAME_OVER cycle (timer still 0) is
                // ignored so the score clear downstream always sees >= 2 cycles.
                if ((r_go_timer == c_GO_LAST) ||
                    (r_start_press && (r_go_timer != '0))) begin
                    w_state_nxt = c_ST_START;
                end
            end
            default: begin
                w_state_nxt = c_ST_START;
            end
        endcase
    end

    // Dwell timer: held at 0 outside GAME_OVER, so it is 0 on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_go_timer <= '0;
        end else if (r_state == c_ST_GAME_OVER) begin
            r_go_timer <= r_go_timer + 1'b1;
        end else begin
            r_go_timer <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Wave counter. The edge register tracks game_status[1] in every
    // state, so an edge seen while PAUSED is consumed and never counted.
    // ------------------------------------------------------------------
    logic       r_wave_d;
    logic [3:0] r_wave_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wave_d     <= 1'b0;
            r_wave_count <= '0;
        end else begin
            r_wave_d <= game_status[1];
            if (w_clear_waves) begin
                r_wave_count <= '0;
            end else if ((r_state == c_ST_PLAYING) && game_status[1] && !r_wave_d &&
                         (r_wave_count != c_WAVE_MAX)) begin
                r_wave_count <= r_wave_count + 1'b1;
            end
        end
    end

    assign game_state = r_state;
    assign wave_count = r_wave_count;

endmodule
`default_nettype wire
